// File: rtl/sram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sram_arb_pkg
// Purpose : Shared types and constants for the two-port SRAM arbiter.
//           State encoding of the access sequencer, bus widths of the
//           256K x 16 asynchronous SRAM, and the width of the phase counter.
// Revision: 1.0 - initial release
// ============================================================================
package sram_arb_pkg;

  localparam int ADDR_W = 18;
  localparam int DATA_W = 16;
  // Phase counter width; each of SETUP/ACCESS/HOLD may last up to 256 cycles.
  localparam int CNT_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_HOLD   = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

endpackage : sram_arb_pkg
`default_nettype wire

// File: rtl/sram_arb_pick.sv
`default_nettype none
// ============================================================================
// Module  : sram_arb_pick
// Purpose : Two-request grant decision for the SRAM arbiter.
//           Optional macro: SRAM_ARB_ROUND_ROBIN_EN
//             defined   - on a tie, grant the port not granted last; the
//                         last-grant pointer updates on every grant and
//                         reset favours port 0.
//             undefined - fixed priority, port 0 always wins a tie.
// Ports   : clk, rst_n   - clock, synchronous active-low reset
//           req0_i/req1_i - request lines as seen in IDLE
//           grant_en_i    - a grant is being taken this cycle
//           grant1_o      - 1: port 1 wins, 0: port 0 wins (combinational)
// Revision: 1.0 - initial release
// ============================================================================
module sram_arb_pick (
  input  logic clk,
  input  logic rst_n,
  input  logic req0_i,
  input  logic req1_i,
  input  logic grant_en_i,
  output logic grant1_o
);

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  // 1 means port 1 was granted last; reset to 1 so port 0 wins the first tie.
  logic last1_q;

  always_comb begin
    if (req0_i && req1_i) grant1_o = ~last1_q;
    else                  grant1_o = ~req0_i & req1_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)          last1_q <= 1'b1;
    else if (grant_en_i) last1_q <= grant1_o;
  end
`else
  logic w_unused;
  assign w_unused = &{1'b0, clk, rst_n, grant_en_i};
  assign grant1_o = ~req0_i & req1_i;
`endif

endmodule : sram_arb_pick
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : sram_arbiter
// Purpose : Two-port arbiter and cycle-timed sequencer for a 256K x 16
//           asynchronous SRAM. One request is granted at a time and walked
//           through SETUP -> ACCESS -> HOLD -> DONE with programmable
//           lengths. Every output, including the strobes and the bus
//           enable, comes straight from a flop.
//           Optional macro: SRAM_ARB_ROUND_ROBIN_EN (tie-break policy, see
//           sram_arb_pick).
// Ports   : clk, rst_n              - clock, synchronous active-low reset
//           req/we/addr/wdata 0,1   - client requests, held until done
//           done0/done1             - one-cycle completion pulses
//           rdata0/rdata1           - last read result per port
//           busy                    - sequencer not in IDLE
//           ram_en/ram_oe/ram_we    - SRAM strobes, active-low
//           ram_addr, ram_data      - SRAM address and tri-state data bus
// Revision: 1.0 - initial release
// ============================================================================
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int SETUP_CYC  = 1,
  parameter int ACCESS_CYC = 3,
  parameter int HOLD_CYC   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy,
  output logic              ram_en,
  output logic              ram_oe,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  inout  wire  [DATA_W-1:0] ram_data
);

  // Counters load N-1 on state entry and the state ends when they reach 0.
  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] ACCESS_LD = CNT_W'(ACCESS_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                port_q, port_d;
  logic                we_lat_q, we_lat_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                en_q, en_d, oe_q, oe_d, wen_q, wen_d;
  logic                drv_q, drv_d, busy_q, busy_d;
  logic                done0_q, done0_d, done1_q, done1_d;
  logic                w_grant1, w_grant_en, w_active;

  assign w_grant_en = (state_q == ST_IDLE) && (req0 || req1);

  sram_arb_pick u_pick (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_i     (req0),
    .req1_i     (req1),
    .grant_en_i (w_grant_en),
    .grant1_o   (w_grant1)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    port_d   = port_q;
    we_lat_d = we_lat_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;

    case (state_q)
      ST_IDLE: begin
        if (w_grant_en) begin
          state_d  = ST_SETUP;
          cnt_d    = SETUP_LD;
          port_d   = w_grant1;
          we_lat_d = w_grant1 ? we1    : we0;
          addr_d   = w_grant1 ? addr1  : addr0;
          wdata_d  = w_grant1 ? wdata1 : wdata0;
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_ACCESS;
          cnt_d   = ACCESS_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_ACCESS: begin
        if (cnt_q == '0) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LD;
          // Closing edge of the last ACCESS cycle: capture read data.
          if (!we_lat_q) begin
            if (port_q) rdata1_d = ram_data;
            else        rdata0_d = ram_data;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) state_d = ST_DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Pin values are decoded from the next state so they appear on the
    // flops in the same cycle the state does.
    w_active = (state_d == ST_SETUP) || (state_d == ST_ACCESS) ||
               (state_d == ST_HOLD);
    en_d     = ~w_active;
    oe_d     = ~(~we_lat_d && ((state_d == ST_SETUP) || (state_d == ST_ACCESS)));
    wen_d    = ~(we_lat_d && (state_d == ST_ACCESS));
    drv_d    = we_lat_d && w_active;
    busy_d   = (state_d != ST_IDLE);
    done0_d  = (state_d == ST_DONE) && !port_d;
    done1_d  = (state_d == ST_DONE) &&  port_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      port_q   <= 1'b0;
      we_lat_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      en_q     <= 1'b1;
      oe_q     <= 1'b1;
      wen_q    <= 1'b1;
      drv_q    <= 1'b0;
      busy_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      port_q   <= port_d;
      we_lat_q <= we_lat_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      en_q     <= en_d;
      oe_q     <= oe_d;
      wen_q    <= wen_d;
      drv_q    <= drv_d;
      busy_q   <= busy_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
    end
  end

  assign ram_data = drv_q ? wdata_q : {DATA_W{1'bz}};
  assign ram_addr = addr_q;
  assign ram_en   = en_q;
  assign ram_oe   = oe_q;
  assign ram_we   = wen_q;
  assign busy     = busy_q;
  assign done0    = done0_q;
  assign done1    = done1_q;
  assign rdata0   = rdata0_q;
  assign rdata1   = rdata1_q;

endmodule : sram_arbiter
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_sram_arbiter
// Purpose : Self-checking bench for sram_arbiter. A transaction-level model
//           tracks each access by its cycle offset from the accept edge and
//           derives the expected pins from that offset; a pin-level SRAM
//           model answers reads. A second instance covers non-default timing.
//           Honours SRAM_ARB_ROUND_ROBIN_EN for the arbitration rule.
// Revision: 1.0 - initial release
// ============================================================================
module tb_sram_arbiter;

  localparam int S = 1, A = 3, H = 1, L = S + A + H;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req0, req1, we0, we1;
  logic [17:0] addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        done0, done1, busy, ram_en, ram_oe, ram_we;
  logic [15:0] rdata0, rdata1;
  logic [17:0] ram_addr;
  wire  [15:0] ram_data;

  logic [15:0] sram    [0:262143];
  logic [15:0] mem_ref [0:262143];

  // Pin-level SRAM: drives the bus while selected and output-enabled.
  assign ram_data = (ram_en == 1'b0 && ram_oe == 1'b0 && ram_we == 1'b1) ?
                    sram[ram_addr] : 16'hzzzz;

  sram_arbiter u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .done0(done0), .done1(done1), .rdata0(rdata0), .rdata1(rdata1),
    .busy(busy), .ram_en(ram_en), .ram_oe(ram_oe), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_data(ram_data)
  );

  // Second instance with stretched timing, port 0 only.
  logic        d2_req, d2_we;
  logic [17:0] d2_addr, d2_ram_addr;
  logic [15:0] d2_wdata, d2_rdata0, d2_rdata1;
  logic        d2_done0, d2_done1, d2_busy, d2_en, d2_oe, d2_wen;
  wire  [15:0] d2_data;

  sram_arbiter #(.SETUP_CYC(2), .ACCESS_CYC(5), .HOLD_CYC(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .req0(d2_req), .req1(1'b0), .we0(d2_we), .we1(1'b0),
    .addr0(d2_addr), .addr1(18'h0), .wdata0(d2_wdata), .wdata1(16'h0),
    .done0(d2_done0), .done1(d2_done1), .rdata0(d2_rdata0), .rdata1(d2_rdata1),
    .busy(d2_busy), .ram_en(d2_en), .ram_oe(d2_oe), .ram_we(d2_wen),
    .ram_addr(d2_ram_addr), .ram_data(d2_data)
  );

  // ---------------- checking ----------------
  int n_chk = 0, n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_active = 1'b0, m_we = 1'b0, m_port = 1'b0, m_last = 1'b1;
  int          m_t = 0;
  logic [17:0] m_addr = '0, m_addr_o = '0;
  logic [15:0] m_wdata = '0;
  logic [15:0] exp_rd [2];
  int          step_no = 0;
  bit          rand_mode = 1'b0;

  task automatic model_edge();
    bit w;
    if (!rst_n) begin
      // An interrupted write leaves whatever the SRAM actually took.
      if (m_active && m_we && m_t < L) mem_ref[m_addr] = sram[m_addr];
      m_active = 0; m_t = 0; m_addr_o = '0; m_last = 1'b1;
      exp_rd[0] = '0; exp_rd[1] = '0;
    end else if (m_active) begin
      m_t++;
      if (m_t == S + A && !m_we) exp_rd[m_port] = mem_ref[m_addr];
      if (m_t == L && m_we) mem_ref[m_addr] = m_wdata;
      if (m_t == L + 1) m_active = 0;
    end else if (req0 || req1) begin
      if (req0 && req1) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        w = (m_last == 1'b0);
`else
        w = 1'b0;
`endif
      end else begin
        w = !req0;
      end
      m_last   = w;
      m_port   = w;
      m_we     = w ? we1 : we0;
      m_addr   = w ? addr1 : addr0;
      m_wdata  = w ? wdata1 : wdata0;
      m_addr_o = m_addr;
      m_active = 1; m_t = 0;
    end
  endtask

  task automatic check_all();
    bit act;
    act = m_active && (m_t < L);
    check_val("busy",     32'(busy),     32'(m_active));
    check_val("ram_en",   32'(ram_en),   32'(!act));
    check_val("ram_oe",   32'(ram_oe),   32'(!(act && !m_we && m_t < S + A)));
    check_val("ram_we",   32'(ram_we),   32'(!(act && m_we && m_t >= S && m_t < S + A)));
    check_val("ram_addr", 32'(ram_addr), 32'(m_addr_o));
    check_val("done0",    32'(done0),    32'(m_active && m_t == L && !m_port));
    check_val("done1",    32'(done1),    32'(m_active && m_t == L && m_port));
    check_val("rdata0",   32'(rdata0),   32'(exp_rd[0]));
    check_val("rdata1",   32'(rdata1),   32'(exp_rd[1]));
    if (act && m_we)
      check_val("bus_wr", 32'(ram_data), 32'(m_wdata));
    else if (act && !m_we && m_t < S + A)
      check_val("bus_rd", 32'(ram_data), 32'(mem_ref[m_addr]));
    else
      check_val("bus_z", (ram_data === 16'hzzzz) ? 32'h0 : 32'(ram_data), 32'h0);
  endtask

  // ---------------- stimulus helpers ----------------
  int cnt_en, cnt_we, cnt_oe, cnt_d0, cnt_d1;
  int dut_acc_step = 0;
  logic [17:0] dut_acc_addr = '0;
  bit prev_busy = 1'b0;
  logic [17:0] addr_tab [8] = '{18'h00000, 18'h00010, 18'h3FFFF, 18'h00011,
                                18'h20000, 18'h1FFFF, 18'h00001, 18'h3FFFE};

  task automatic clear_cnt();
    cnt_en = 0; cnt_we = 0; cnt_oe = 0; cnt_d0 = 0; cnt_d1 = 0;
  endtask

  task automatic issue(input int p, input bit we, input logic [17:0] a,
                       input logic [15:0] d);
    if (p == 0) begin req0 = 1; we0 = we; addr0 = a; wdata0 = d; end
    else        begin req1 = 1; we1 = we; addr1 = a; wdata1 = d; end
  endtask

  task automatic issue_rand(input int p);
    issue(p, 1'($urandom_range(0, 1)), addr_tab[$urandom_range(0, 7)],
          16'($urandom));
  endtask

  // One clock: model on the edge, check 1 time unit later, drive at negedge.
  task automatic step();
    @(posedge clk);
    step_no++;
    model_edge();
    #1;
    check_all();
    if (ram_en === 1'b0 && ram_we === 1'b0) sram[ram_addr] = ram_data;
    if (ram_en == 1'b0) cnt_en++;
    if (ram_we == 1'b0) cnt_we++;
    if (ram_oe == 1'b0) cnt_oe++;
    if (done0) cnt_d0++;
    if (done1) cnt_d1++;
    if (busy && !prev_busy) begin dut_acc_step = step_no; dut_acc_addr = ram_addr; end
    prev_busy = busy;
    @(negedge clk);
    if (m_active && m_t == L) begin
      if (m_port) req1 = 0; else req0 = 0;
    end
    if (rand_mode) begin
      if (!req0 && $urandom_range(0, 2) == 0) issue_rand(0);
      if (!req1 && $urandom_range(0, 2) == 0) issue_rand(1);
    end
  endtask

  // Steps until the DUT pulses done on port p; lat = edges after accept.
  task automatic wait_done(input int p, output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if ((p == 0 ? done0 : done1) == 1'b1) begin lat = k - 1; break; end
    end
    if (lat < 0) check_val("wait_done_timeout", 32'h0, 32'h1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat, a1, g, seen, en_l, we_l;
    bit got;
    for (int i = 0; i < 262144; i++) begin sram[i] = '0; mem_ref[i] = '0; end
    exp_rd[0] = '0; exp_rd[1] = '0;
    rst_n = 0; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    d2_req = 0; d2_we = 0; d2_addr = '0; d2_wdata = '0;
    clear_cnt();
    @(negedge clk);
    repeat (3) step();
    rst_n = 1;
    step();

    // Port 0 write
    clear_cnt();
    issue(0, 1'b1, 18'h00010, 16'hA5A5);
    wait_done(0, lat);
    check_val("wr_latency", 32'(lat), 32'd5);
    check_val("wr_en_low",  32'(cnt_en), 32'd5);
    check_val("wr_we_low",  32'(cnt_we), 32'd3);
    check_val("wr_landed",  32'(sram[18'h00010]), 32'hA5A5);
    step();

    // Port 1 read back
    clear_cnt();
    issue(1, 1'b0, 18'h00010, 16'h0000);
    wait_done(1, lat);
    check_val("rd_latency", 32'(lat), 32'd5);
    check_val("rd_oe_low",  32'(cnt_oe), 32'd4);
    check_val("rd_rdata1",  32'(rdata1), 32'hA5A5);
    check_val("rd_done0",   32'(cnt_d0), 32'd0);
    step();

    // Simultaneous requests, re-raised after each grant
    issue(0, 1'b1, 18'h00100, 16'h1111);
    issue(1, 1'b1, 18'h00101, 16'h2222);
    for (g = 0; g < 4; g++) begin
      got = 0; seen = 0;
      for (int k = 0; k < 20 && !got; k++) begin
        step();
        if (done0 || done1) begin got = 1; seen = done1 ? 1 : 0; end
      end
      if (!got) check_val("tie_timeout", 32'h0, 32'h1);
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      check_val("tie_grant", 32'(seen), 32'(g % 2));
`else
      check_val("tie_grant", 32'(seen), 32'd0);
`endif
      step();
      if (g < 3) issue(seen, 1'b1, 18'h00100 + 18'(seen), 16'(16'h1000 * (g + 3)));
    end
    for (int k = 0; k < 40 && (req0 || req1 || m_active); k++) step();
    check_val("tie_drain", 32'(req1 || m_active), 32'h0);

    // Stretched timing instance
    d2_req = 1; d2_we = 1; d2_addr = 18'h00123; d2_wdata = 16'h5A5A;
    lat = -1; en_l = 0; we_l = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (d2_en == 1'b0) en_l++;
      if (d2_wen == 1'b0) we_l++;
      if (d2_done0 && lat < 0) begin lat = k - 1; d2_req = 0; end
    end
    check_val("d2_latency", 32'(lat), 32'd9);
    check_val("d2_en_low",  32'(en_l), 32'd9);
    check_val("d2_we_low",  32'(we_l), 32'd5);
    check_val("d2_busy",    32'(d2_busy), 32'd0);

    // Reset in the middle of a write's ACCESS phase
    issue(0, 1'b1, 18'h00200, 16'hBEEF);
    for (int k = 0; k < 20 && !(m_active && m_t == S + 1); k++) step();
    rst_n = 0; req0 = 0; req1 = 0;
    clear_cnt();
    step();
    check_val("rst_busy",  32'(busy), 32'd0);
    check_val("rst_we",    32'(ram_we), 32'd1);
    check_val("rst_en",    32'(ram_en), 32'd1);
    rst_n = 1;
    step();
    check_val("rst_nodone", 32'(cnt_d0 + cnt_d1), 32'd0);
    issue(1, 1'b0, 18'h00010, 16'h0000);
    wait_done(1, lat);
    check_val("post_rst_lat",   32'(lat), 32'd5);
    check_val("post_rst_rdata", 32'(rdata1), 32'hA5A5);
    step();

    // Back-to-back on port 0: read top address then write address 0
    issue(0, 1'b0, 18'h3FFFF, 16'h0000);
    step();
    a1 = dut_acc_step;
    check_val("b2b_addr1", 32'(dut_acc_addr), 32'h3FFFF);
    wait_done(0, lat);
    step();
    issue(0, 1'b1, 18'h00000, 16'h1234);
    step();
    check_val("b2b_spacing", 32'(dut_acc_step - a1), 32'd7);
    check_val("b2b_addr2",   32'(dut_acc_addr), 32'h00000);
    wait_done(0, lat);
    step();

    // Randomized traffic on both ports
    rand_mode = 1;
    repeat (600) step();
    rand_mode = 0;
    for (int k = 0; k < 60 && (req0 || req1 || m_active); k++) step();
    check_val("final_idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule : tb_sram_arbiter
`default_nettype wire
